perf_counter_reader: RTL and testbench

- Read-out side of the performance-counter block.
- Accepts a read request, atomically snapshots the full flattened counter vector, and streams it as OUT_WIDTH-bit words over a valid/ready interface toward the debug/host link.
- Optionally requests a counter clear, timed so the clear falls right after the snapshot.
- Sits between the counter accumulator (source of counterIn, sink of clearPulse) and the debug transport.

---
 rtl/perf_counter_reader.sv | 75 +++++++
 tb/tb_perf_counter_reader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/perf_counter_reader.sv
// perf_counter_reader: snapshots the flattened counter vector on request and streams it as OUT_WIDTH-bit words
module perf_counter_reader #(
    parameter int NUM_COUNTERS  = 10,
    parameter int COUNTER_WIDTH = 64,
    parameter int OUT_WIDTH     = 32,
    localparam int WORDS_PER_CNT = COUNTER_WIDTH / OUT_WIDTH,
    localparam int NUM_WORDS     = NUM_COUNTERS * WORDS_PER_CNT,
    localparam int IDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counterIn,
    input  logic                                  reqValid,
    input  logic                                  reqClear,
    output logic                                  reqReady,
    output logic                                  outValid,
    input  logic                                  outReady,
    output logic [OUT_WIDTH-1:0]                  outData,
    output logic [IDX_W-1:0]                      outIndex,
    output logic                                  outLast,
    output logic                                  clearPulse,
    output logic                                  busy
);
    typedef enum logic {IDLE, STREAM} state_t;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    state_t                                r_state;
    logic [IDX_W-1:0]                      r_idx;
    logic                                  r_clear;
    logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] r_snap;
    logic [OUT_WIDTH-1:0]                  w_words [NUM_WORDS];
    logic                                  w_accept;
    logic                                  w_xfer;
    logic                                  w_last;
    genvar g;
    for (g = 0; g < NUM_WORDS; g++) begin : g_words
        assign w_words[g] = r_snap[g*OUT_WIDTH +: OUT_WIDTH];
    end
    assign w_accept   = reqValid && (r_state == IDLE);
    assign w_last     = (r_state == STREAM) && (r_idx == LAST_IDX);
    assign w_xfer     = (r_state == STREAM) && outReady;
    assign reqReady   = (r_state == IDLE);
    assign busy       = (r_state == STREAM);
    assign outValid   = (r_state == STREAM);
    assign outLast    = w_last;
    assign outIndex   = r_idx;
    assign outData    = (r_state == STREAM) ? w_words[r_idx] : '0;
    assign clearPulse = r_clear;
    // Capture the whole counter vector on the accept edge so the stream is atomic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_snap <= '0;
        else if (w_accept)
            r_snap <= counterIn;
    end
    // Stream FSM: word index, state and the one-cycle clear issued in the first STREAM cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_clear <= 1'b0;
        end else begin
            r_clear <= 1'b0;
            if (w_accept) begin
                r_state <= STREAM;
                r_idx   <= '0;
                r_clear <= reqClear;
            end else if (w_xfer) begin
                if (w_last)
                    r_state <= IDLE;
                else
                    r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_perf_counter_reader.sv
// tb_perf_counter_reader: directed scoreboard bench for perf_counter_reader (4-word configuration)
module tb_perf_counter_reader;
    typedef struct {
        logic [31:0] d;
        logic [1:0]  i;
        logic        l;
    } word_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] counterIn = '0;
    logic         reqValid = 1'b0;
    logic         reqClear = 1'b0;
    logic         reqReady;
    logic         outValid;
    logic         outReady = 1'b0;
    logic [31:0]  outData;
    logic [1:0]   outIndex;
    logic         outLast;
    logic         clearPulse;
    logic         busy;
    int           checks = 0;
    int           errors = 0;
    int           vcnt = 0;
    int           ccnt = 0;
    bit           m_busy = 1'b0;
    bit           exp_clr = 1'b0;
    word_t        sb[$];
    perf_counter_reader #(.NUM_COUNTERS(2), .COUNTER_WIDTH(64), .OUT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .counterIn(counterIn), .reqValid(reqValid), .reqClear(reqClear),
        .reqReady(reqReady), .outValid(outValid), .outReady(outReady), .outData(outData),
        .outIndex(outIndex), .outLast(outLast), .clearPulse(clearPulse), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // One clock: model the coming edge at the negedge, then check state after the posedge
    task automatic tick();
        word_t w;
        bit    acc;
        bit    xfer;
        @(negedge clk);
        acc  = rst_n && reqValid && !m_busy;
        xfer = rst_n && m_busy && outReady;
        exp_clr = acc && reqClear;
        if (xfer) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'(sb.size()), 64'd1);
                m_busy = 1'b0;
            end else begin
                w = sb.pop_front();
                chk("word_data", 64'(outData), 64'(w.d));
                chk("word_index", 64'(outIndex), 64'(w.i));
                chk("word_last", 64'(outLast), 64'(w.l));
                if (w.l) m_busy = 1'b0;
            end
        end
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                w.d = counterIn[k*32 +: 32];
                w.i = 2'(k);
                w.l = (k == 3);
                sb.push_back(w);
            end
            m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("outValid", 64'(outValid), 64'(m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("reqReady", 64'(reqReady), 64'(!m_busy));
        chk("clearPulse", 64'(clearPulse), 64'(exp_clr));
        if (outValid) vcnt++;
        if (clearPulse) ccnt++;
    endtask
    initial begin
        tick();
        tick();
        chk("rst_reqReady", 64'(reqReady), 64'd1);
        chk("rst_outIndex", 64'(outIndex), 64'd0);
        chk("rst_outLast", 64'(outLast), 64'd0);
        chk("rst_outData", 64'(outData), 64'd0);
        rst_n = 1'b1;
        tick();
        // basic read
        counterIn = {64'h0000_0002_0000_0003, 64'h0000_0004_0000_0005};
        outReady = 1'b1;
        vcnt = 0;
        ccnt = 0;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        chk("basic_valid", 64'(outValid), 64'd1);
        chk("basic_word0", 64'(outData), 64'h5);
        for (int n = 0; n < 4; n++) tick();
        chk("basic_ready_after", 64'(reqReady), 64'd1);
        chk("basic_vcycles", 64'(vcnt), 64'd4);
        chk("basic_noclear", 64'(ccnt), 64'd0);
        // backpressure on word 1
        vcnt = 0;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        tick();
        outReady = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("bp_data", 64'(outData), 64'h4);
            chk("bp_index", 64'(outIndex), 64'd1);
        end
        outReady = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        chk("bp_vcycles", 64'(vcnt), 64'd7);
        // atomic snapshot with live counters changing every cycle
        counterIn = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            counterIn = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        // clear after snapshot
        ccnt = 0;
        counterIn = {64'h0000_00AA_0000_00BB, 64'h0000_00CC_0000_00DD};
        reqValid = 1'b1;
        reqClear = 1'b1;
        tick();
        reqValid = 1'b0;
        reqClear = 1'b0;
        chk("clr_first", 64'(clearPulse), 64'd1);
        counterIn = '0;
        for (int n = 0; n < 4; n++) tick();
        chk("clr_once", 64'(ccnt), 64'd1);
        // request held through the stream: one bubble, then a second stream
        counterIn = {64'h0000_0002_0000_0003, 64'h0000_0004_0000_0005};
        reqValid = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        chk("busy_bubble_valid", 64'(outValid), 64'd0);
        chk("busy_bubble_ready", 64'(reqReady), 64'd1);
        tick();
        reqValid = 1'b0;
        chk("busy_second_valid", 64'(outValid), 64'd1);
        chk("busy_second_index", 64'(outIndex), 64'd0);
        for (int n = 0; n < 4; n++) tick();
        // asynchronous reset at word 2
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        tick();
        tick();
        chk("ar_index_before", 64'(outIndex), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_outValid", 64'(outValid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_reqReady", 64'(reqReady), 64'd1);
        sb.delete();
        m_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        chk("ar_restart_index", 64'(outIndex), 64'd0);
        chk("ar_restart_data", 64'(outData), 64'h5);
        for (int n = 0; n < 4; n++) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
